alu_op_sequencer: RTL and testbench

Command front-end and result back-end wrapped around the team's combinational 4-bit operations unit. Accepts opcode/operand commands over a valid/ready handshake. Registers the operands onto the unit's A/B inputs and selects the one result named by the opcode. Pushes the result and status flags into a small output FIFO, which drains to the consumer over a second valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end and result FIFO around a 4-bit ops unit; ALU_SEQ_STATS_EN adds push/error counters
module alu_op_sequencer #(
   parameter int OUT_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [7:0] alu_sum,
   input  logic [7:0] alu_diff,
   input  logic [7:0] alu_prod,
   input  logic [7:0] alu_quot,
   input  logic [3:0] alu_and,
   input  logic [3:0] alu_or,
   input  logic [3:0] alu_xor,
   input  logic [3:0] alu_not_a,
   input  logic [3:0] alu_not_b,
`ifdef ALU_SEQ_STATS_EN
   output logic [15:0] stat_ops,
   output logic [7:0]  stat_errs,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic [3:0] out_op,
   output logic       out_zero,
   output logic       out_div0,
   output logic       out_illegal
);
   localparam int AW = $clog2(OUT_DEPTH);
   typedef enum logic {IDLE, EXEC} state_t;
   state_t r_state;
   logic [3:0] r_op;
   logic [7:0] r_res_mem [OUT_DEPTH];
   logic [3:0] r_op_mem [OUT_DEPTH];
   logic [2:0] r_flg_mem [OUT_DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0] r_cnt;
   logic [7:0] w_raw, w_res;
   logic w_push, w_pop, w_div0, w_ill;
   assign in_ready = !rst && r_state == IDLE && r_cnt < (AW+1)'(OUT_DEPTH);
   assign w_push = r_state == EXEC;
   assign w_pop = out_valid && out_ready;
   assign w_div0 = r_op == 4'd3 && alu_b == 4'd0;
   assign w_ill = r_op > 4'd8;
   assign w_res = w_ill ? 8'h00 : w_div0 ? 8'hFF : w_raw;
   assign out_valid = r_cnt != '0;
   assign out_result = r_res_mem[r_rd];
   assign out_op = r_op_mem[r_rd];
   assign {out_zero, out_div0, out_illegal} = r_flg_mem[r_rd];
   // pick the ops unit output named by the latched opcode
   always_comb begin
      w_raw = 8'h00;
      case (r_op)
         4'd0: w_raw = alu_sum;
         4'd1: w_raw = alu_diff;
         4'd2: w_raw = alu_prod;
         4'd3: w_raw = alu_quot;
         4'd4: w_raw = {4'h0, alu_and};
         4'd5: w_raw = {4'h0, alu_or};
         4'd6: w_raw = {4'h0, alu_xor};
         4'd7: w_raw = {4'h0, alu_not_a};
         4'd8: w_raw = {4'h0, alu_not_b};
         default: w_raw = 8'h00;
      endcase
   end
   // accept a command in IDLE, push its result one cycle later in EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_op <= '0;
         alu_a <= '0;
         alu_b <= '0;
      end else if (r_state == IDLE) begin
         if (in_valid && in_ready) begin
            r_op <= in_op;
            alu_a <= in_a;
            alu_b <= in_b;
            r_state <= EXEC;
         end
      end else begin
         r_state <= IDLE;
      end
   end
   // circular result buffer; space was reserved at accept so a push never overflows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
         r_cnt <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_res_mem[i] <= '0;
            r_op_mem[i] <= '0;
            r_flg_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_res_mem[r_wr] <= w_res;
            r_op_mem[r_wr] <= r_op;
            r_flg_mem[r_wr] <= {w_res == 8'h00, w_div0, w_ill};
            r_wr <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
`ifdef ALU_SEQ_STATS_EN
   // saturating counts of pushes and of pushes flagged div0 or illegal
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ops <= '0;
         stat_errs <= '0;
      end else if (w_push) begin
         if (stat_ops != '1) stat_ops <= stat_ops + 16'd1;
         if ((w_div0 || w_ill) && stat_errs != '1) stat_errs <= stat_errs + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with a behavioural ops unit; ALU_SEQ_STATS_EN also checks the counters
module tb_alu_op_sequencer;
   logic clk = 0, rst = 1;
   logic in_valid = 0, in_ready, out_ready = 1;
   logic [3:0] in_op = 0, in_a = 0, in_b = 0, alu_a, alu_b, out_op;
   logic [7:0] alu_sum, alu_diff, alu_prod, alu_quot, out_result;
   logic [3:0] alu_and, alu_or, alu_xor, alu_not_a, alu_not_b;
   logic out_valid, out_zero, out_div0, out_illegal;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0] stat_ops;
   logic [7:0] stat_errs;
`endif
   int vecs = 0, errs = 0;
   always #5 clk = ~clk;
   assign alu_sum = {4'h0, alu_a} + {4'h0, alu_b};
   assign alu_diff = {4'h0, alu_a} - {4'h0, alu_b};
   assign alu_prod = {4'h0, alu_a} * {4'h0, alu_b};
   assign alu_quot = (alu_b == 4'h0) ? 8'hEE : {4'h0, alu_a} / {4'h0, alu_b};
   assign alu_and = alu_a & alu_b;
   assign alu_or = alu_a | alu_b;
   assign alu_xor = alu_a ^ alu_b;
   assign alu_not_a = ~alu_a;
   assign alu_not_b = ~alu_b;
   alu_op_sequencer #(.OUT_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sum(alu_sum), .alu_diff(alu_diff), .alu_prod(alu_prod), .alu_quot(alu_quot),
      .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
      .alu_not_a(alu_not_a), .alu_not_b(alu_not_b),
`ifdef ALU_SEQ_STATS_EN
      .stat_ops(stat_ops), .stat_errs(stat_errs),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_op(out_op), .out_zero(out_zero), .out_div0(out_div0), .out_illegal(out_illegal)
   );
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chk_head(input string tag, input logic [3:0] op, input logic [7:0] res,
                           input logic z, input logic d, input logic il);
      chk({tag, "_valid"}, 16'(out_valid), 16'd1);
      chk({tag, "_res"}, {out_op, out_result}, {op, res});
      chk({tag, "_flags"}, 16'({out_zero, out_div0, out_illegal}), 16'({z, d, il}));
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      int n = 0;
      in_valid = 1;
      in_op = op;
      in_a = a;
      in_b = b;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", 16'(in_ready), 16'd1);
      tick();
      in_valid = 0;
   endtask
   initial begin
      logic [3:0] ops [7] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      logic [7:0] exp [7] = '{8'hFB, 8'h96, 8'h0A, 8'h0F, 8'h05, 8'h05, 8'h00};
      tick();
      tick();
      chk("rst_ready", 16'(in_ready), 16'd0);
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_head", {out_op, out_result}, 16'h0000);
      chk("rst_alu", {8'h00, alu_a, alu_b}, 16'h0000);
      rst = 0;
      #1;
      chk("post_rst_ready", 16'(in_ready), 16'd1);
      send(4'd0, 4'hA, 4'hF);
      chk("exec_ready", 16'(in_ready), 16'd0);
      chk("exec_no_valid", 16'(out_valid), 16'd0);
      tick();
      chk_head("add", 4'd0, 8'h19, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         send(ops[i], 4'hA, 4'hF);
         tick();
         chk_head($sformatf("op%0d", ops[i]), ops[i], exp[i], exp[i] == 8'h00, 0, 0);
      end
      send(4'd3, 4'h7, 4'h0);
      tick();
      chk_head("div0", 4'd3, 8'hFF, 0, 1, 0);
      send(4'd3, 4'h9, 4'h2);
      tick();
      chk_head("div", 4'd3, 8'h04, 0, 0, 0);
      send(4'd12, 4'h9, 4'h2);
      tick();
      chk_head("illegal", 4'd12, 8'h00, 1, 0, 1);
      tick();
      chk("drained", 16'(out_valid), 16'd0);
      out_ready = 0;
      send(4'd0, 4'h1, 4'h2);
      tick();
      send(4'd0, 4'h3, 4'h4);
      tick();
      chk("full_ready", 16'(in_ready), 16'd0);
      in_valid = 1;
      in_op = 4'd0;
      in_a = 4'h5;
      in_b = 4'h6;
      tick();
      chk("stall_ready", 16'(in_ready), 16'd0);
      chk_head("hold", 4'd0, 8'h03, 0, 0, 0);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("one_pop_ready", 16'(in_ready), 16'd1);
      chk_head("pop1", 4'd0, 8'h07, 0, 0, 0);
      tick();
      in_valid = 0;
      chk("third_exec", 16'(in_ready), 16'd0);
      tick();
      chk("refull_ready", 16'(in_ready), 16'd0);
      chk_head("pop2", 4'd0, 8'h07, 0, 0, 0);
      out_ready = 1;
      tick();
      chk_head("pop3", 4'd0, 8'h0B, 0, 0, 0);
      tick();
      chk("empty_after3", 16'(out_valid), 16'd0);
      send(4'd0, 4'h1, 4'h1);
      rst = 1;
      #1;
      chk("mid_rst_valid", 16'(out_valid), 16'd0);
      chk("mid_rst_ready", 16'(in_ready), 16'd0);
      tick();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_ghost", 16'(out_valid), 16'd0);
      end
      send(4'd0, 4'h2, 4'h2);
      tick();
      chk_head("post_rst_add", 4'd0, 8'h04, 0, 0, 0);
`ifdef ALU_SEQ_STATS_EN
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("stat_ops_rst0", stat_ops, 16'd0);
      for (int i = 0; i < 4; i++) begin
         send(4'd0, 4'(i), 4'h1);
         tick();
      end
      send(4'd3, 4'h5, 4'h0);
      tick();
      send(4'd9, 4'h5, 4'h1);
      tick();
      chk("stat_ops", stat_ops, 16'd6);
      chk("stat_errs", 16'(stat_errs), 16'd2);
      rst = 1;
      #1;
      chk("stat_ops_rst", stat_ops, 16'd0);
      chk("stat_errs_rst", 16'(stat_errs), 16'd0);
      rst = 0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
